inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl_pkg.sv | 21 ++
 rtl/inst_fetch_ctrl_if.sv | 26 ++
 rtl/inst_fetch_ctrl_fifo.sv | 66 ++++++
 rtl/inst_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared fetch-stage types: FSM state encoding, fetch buffer payload and helpers.
package corePckg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } tFetchState;

  localparam logic [31:0] cInstNop = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } tFetchEntry;

  function automatic logic isMisaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and decoder handshake.
interface inst_fetch_ctrl_if;

  logic        iEnable;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        oImemRe;
  logic [31:0] oImemAddr;
  logic [31:0] iImemData;
  logic [31:0] oInst;
  logic [31:0] oCurPc;
  logic        oValid;
  logic        iReady;
  logic        oMisalign;

  modport master (
    input  iEnable, iRedirect, iRedirectPc, iImemData, iReady,
    output oImemRe, oImemAddr, oInst, oCurPc, oValid, oMisalign
  );

  modport slave (
    output iEnable, iRedirect, iRedirectPc, iImemData, iReady,
    input  oImemRe, oImemAddr, oInst, oCurPc, oValid, oMisalign
  );

endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// First-word-fall-through buffer of fetched {pc, inst} entries with synchronous flush.
module inst_fifo
  import corePckg::*;
#(
  parameter int unsigned depth = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  tFetchEntry               i_data,
  output tFetchEntry               o_data,
  output logic [$clog2(depth):0]   o_count
);

  localparam int unsigned cPtrW = $clog2(depth);
  localparam logic [cPtrW:0] cFull = depth[cPtrW:0];

  tFetchEntry         r_mem [depth];
  logic [cPtrW-1:0]   r_wr_ptr;
  logic [cPtrW-1:0]   r_rd_ptr;
  logic [cPtrW:0]     r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The fetch credit rule upstream must never let a push land on a full buffer.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_do_push && !w_do_pop && (r_count == cFull)))
    else $error("inst_fifo: push into full buffer");

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: credit-based imem reads into a FWFT buffer feeding the decoder.
module inst_fetch_ctrl
  import corePckg::*;
#(
  parameter logic [31:0] cResetPc   = 32'h0000_0000,
  parameter int unsigned cFifoDepth = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  inst_fetch_ctrl_if.master ifc
);

  localparam int unsigned     cCntW   = $clog2(cFifoDepth) + 1;
  localparam logic [cCntW:0]  cDepthW = cFifoDepth[cCntW:0];

  tFetchState        r_state;
  tFetchState        w_state_nxt;
  logic [31:0]       r_fetch_pc;
  logic              r_inflight;
  logic [31:0]       r_inflight_pc;
  logic              r_misalign;

  logic [cCntW-1:0]  w_count;
  logic [cCntW:0]    w_occupancy;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_redirect_bad;
  tFetchEntry        w_push_data;
  tFetchEntry        w_head;

  assign w_redirect_bad = ifc.iRedirect && isMisaligned(ifc.iRedirectPc);
  assign w_valid        = (w_count != '0);
  assign w_pop          = w_valid && ifc.iReady;

  // Slots already claimed (buffered + outstanding) net of this cycle's pop.
  assign w_occupancy = {1'b0, w_count}
                     + {{cCntW{1'b0}}, r_inflight}
                     - {{cCntW{1'b0}}, w_pop};
  assign w_issue     = (r_state == RUN) && !ifc.iRedirect && (w_occupancy < cDepthW);

  // The outstanding read's data arrives in the cycle after issue; a redirect in
  // that cycle kills it by withholding the push while the buffer is flushed.
  assign w_push      = r_inflight && !ifc.iRedirect;
  assign w_push_data = '{pc: r_inflight_pc, inst: ifc.iImemData};

  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect_bad) begin
      w_state_nxt = ERR;
    end else begin
      case (r_state)
        IDLE:    if (ifc.iEnable)  w_state_nxt = RUN;
        RUN:     if (!ifc.iEnable) w_state_nxt = IDLE;
        ERR:     w_state_nxt = ERR;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state       <= IDLE;
      r_fetch_pc    <= cResetPc;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
      end
      if (ifc.iRedirect) begin
        r_fetch_pc <= ifc.iRedirectPc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_redirect_bad) begin
        r_misalign <= 1'b1;
      end
    end
  end

  inst_fifo #(
    .depth (cFifoDepth)
  ) u_fifo (
    .i_clk   (iClk),
    .i_rst_n (iRst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (ifc.iRedirect),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign ifc.oImemRe   = w_issue;
  assign ifc.oImemAddr = r_fetch_pc;
  assign ifc.oInst     = w_head.inst;
  assign ifc.oCurPc    = w_head.pc;
  assign ifc.oValid    = w_valid;
  assign ifc.oMisalign = r_misalign;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with an imem responder feeding an expected-delivery queue.
module tb_inst_fetch_ctrl;
  import corePckg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl #(
    .cResetPc   (32'h0000_0000),
    .cFifoDepth (2)
  ) dut (
    .iClk (clk),
    .iRst (rst_n),
    .ifc  (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_deliv = 0;
  int base;
  tFetchEntry exp_q[$];
  logic        mem_rd;
  logic [31:0] mem_a;
  tFetchEntry  mem_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; the responder updates at +1.
  task automatic advance();
    @(posedge clk);
    #2;
  endtask

  // Falling-edge sample: every decoder transfer must match the oldest answered read.
  task automatic sample();
    tFetchEntry e;
    @(negedge clk);
    if (rst_n === 1'b1 && bus.oValid === 1'b1 && bus.iReady === 1'b1) begin
      n_deliv++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL deliver_unexpected observed pc=%h expected=no delivery", bus.oCurPc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliver_pc", bus.oCurPc, e.pc);
        chk("deliver_inst", bus.oInst, e.inst);
      end
    end
  endtask

  // Instruction memory: data valid exactly one cycle after the read strobe.
  initial begin
    bus.iImemData = cInstNop;
    forever begin
      @(negedge clk);
      mem_rd = bus.oImemRe;
      mem_a  = bus.oImemAddr;
      @(posedge clk);
      #1;
      if (mem_rd === 1'b1) begin
        bus.iImemData = mem_word(mem_a);
        mem_e = '{pc: mem_a, inst: mem_word(mem_a)};
        exp_q.push_back(mem_e);
      end else begin
        bus.iImemData = cInstNop;
      end
    end
  end

  initial begin
    rst_n           = 1'b0;
    bus.iEnable     = 1'b0;
    bus.iRedirect   = 1'b0;
    bus.iRedirectPc = '0;
    bus.iReady      = 1'b0;

    // Reset state
    sample();
    chk1("rst_re", bus.oImemRe, 1'b0);
    chk1("rst_valid", bus.oValid, 1'b0);
    chk1("rst_misalign", bus.oMisalign, 1'b0);
    chk("rst_addr", bus.oImemAddr, 32'h0);
    chk("rst_inst", bus.oInst, 32'h0);
    chk("rst_curpc", bus.oCurPc, 32'h0);
    advance(); rst_n = 1'b1;
    sample(); chk1("idle_no_read", bus.oImemRe, 1'b0);

    // Start-up latency and sustained throughput
    advance(); bus.iEnable = 1'b1; bus.iReady = 1'b1;
    sample(); chk1("en_cycle_no_read", bus.oImemRe, 1'b0);
    advance(); sample();
    chk1("rd0_re", bus.oImemRe, 1'b1); chk("rd0_addr", bus.oImemAddr, 32'h0);
    chk1("rd0_valid", bus.oValid, 1'b0);
    advance(); sample();
    chk1("rd1_re", bus.oImemRe, 1'b1); chk("rd1_addr", bus.oImemAddr, 32'h4);
    chk1("rd1_valid", bus.oValid, 1'b0);
    advance(); sample();
    chk1("rd2_re", bus.oImemRe, 1'b1); chk("rd2_addr", bus.oImemAddr, 32'h8);
    chk1("first_valid", bus.oValid, 1'b1); chk("first_curpc", bus.oCurPc, 32'h0);
    base = n_deliv;
    repeat (6) begin
      advance(); sample();
      chk1("stream_re", bus.oImemRe, 1'b1);
      chk1("stream_valid", bus.oValid, 1'b1);
    end
    chk("stream_rate", n_deliv - base, 32'd6);

    // Asynchronous reset mid-burst, then restart with the decoder stalled
    advance(); #1; rst_n = 1'b0; #1;
    chk1("midrst_valid", bus.oValid, 1'b0);
    chk1("midrst_re", bus.oImemRe, 1'b0);
    chk("midrst_addr", bus.oImemAddr, 32'h0);
    chk("midrst_curpc", bus.oCurPc, 32'h0);
    exp_q.delete();
    bus.iReady = 1'b0;
    advance(); sample();
    advance(); rst_n = 1'b1;
    sample(); chk1("restart_wait", bus.oImemRe, 1'b0);
    advance(); sample();
    chk1("restart_re", bus.oImemRe, 1'b1); chk("restart_addr", bus.oImemAddr, 32'h0);
    advance(); sample();
    chk1("stall_rd1_re", bus.oImemRe, 1'b1); chk("stall_rd1_addr", bus.oImemAddr, 32'h4);
    advance(); sample();
    chk1("stall_credit_re", bus.oImemRe, 1'b0); chk1("stall_valid1", bus.oValid, 1'b1);
    repeat (5) begin
      advance(); sample();
      chk1("stall_re", bus.oImemRe, 1'b0);
      chk1("stall_valid", bus.oValid, 1'b1);
      chk("stall_head", bus.oCurPc, 32'h0);
    end
    advance(); bus.iReady = 1'b1;
    base = n_deliv;
    sample(); chk1("resume_re", bus.oImemRe, 1'b1); chk("resume_addr", bus.oImemAddr, 32'h8);
    advance(); sample(); chk("resume_addr2", bus.oImemAddr, 32'hC);
    repeat (4) begin advance(); sample(); end
    chk("resume_rate", n_deliv - base, 32'd6);

    // Redirect with a read outstanding
    advance(); bus.iRedirect = 1'b1; bus.iRedirectPc = 32'h100;
    sample(); chk1("redir_no_read", bus.oImemRe, 1'b0);
    advance(); bus.iRedirect = 1'b0; exp_q.delete();
    sample();
    chk1("redir_flush_valid", bus.oValid, 1'b0);
    chk1("redir_re", bus.oImemRe, 1'b1); chk("redir_addr", bus.oImemAddr, 32'h100);
    advance(); sample();
    chk1("redir_valid2", bus.oValid, 1'b0); chk("redir_addr2", bus.oImemAddr, 32'h104);
    advance(); sample();
    chk1("redir_valid3", bus.oValid, 1'b1); chk("redir_curpc", bus.oCurPc, 32'h100);

    // Redirect coinciding with a pop from a full buffer
    advance(); bus.iReady = 1'b0;
    sample();
    repeat (3) begin advance(); sample(); end
    chk1("full_valid", bus.oValid, 1'b1); chk1("full_re", bus.oImemRe, 1'b0);
    advance(); bus.iReady = 1'b1; bus.iRedirect = 1'b1; bus.iRedirectPc = 32'h200;
    base = n_deliv;
    sample(); chk1("rpop_no_read", bus.oImemRe, 1'b0);
    chk("rpop_once", n_deliv - base, 32'd1);
    advance(); bus.iRedirect = 1'b0; exp_q.delete();
    base = n_deliv;
    sample();
    chk1("rpop_valid", bus.oValid, 1'b0); chk("rpop_addr", bus.oImemAddr, 32'h200);
    advance(); sample(); chk1("rpop_valid2", bus.oValid, 1'b0);
    advance(); sample();
    chk1("rpop_valid3", bus.oValid, 1'b1); chk("rpop_curpc", bus.oCurPc, 32'h200);
    chk("rpop_no_stale", n_deliv - base, 32'd1);

    // Dropping enable drains the outstanding read and buffer
    advance(); bus.iEnable = 1'b0;
    sample();
    advance(); sample(); chk1("drop_re1", bus.oImemRe, 1'b0);
    advance(); sample(); chk1("drop_re2", bus.oImemRe, 1'b0);
    advance(); sample();
    chk1("drained_valid", bus.oValid, 1'b0);
    chk("drained_queue", exp_q.size(), 32'd0);

    // Redirect in IDLE, then fetch across the 32-bit wrap
    advance(); bus.iRedirect = 1'b1; bus.iRedirectPc = 32'hFFFF_FFF8;
    sample(); chk1("idle_redir_re", bus.oImemRe, 1'b0);
    advance(); bus.iRedirect = 1'b0;
    sample();
    chk1("idle_redir_re2", bus.oImemRe, 1'b0);
    chk("idle_redir_addr", bus.oImemAddr, 32'hFFFF_FFF8);
    advance(); bus.iEnable = 1'b1;
    sample(); chk1("idle_wait_run", bus.oImemRe, 1'b0);
    advance(); sample(); chk("wrap_a0", bus.oImemAddr, 32'hFFFF_FFF8);
    chk1("wrap_re", bus.oImemRe, 1'b1);
    advance(); sample(); chk("wrap_a1", bus.oImemAddr, 32'hFFFF_FFFC);
    advance(); sample(); chk("wrap_a2", bus.oImemAddr, 32'h0);
    chk("wrap_cur0", bus.oCurPc, 32'hFFFF_FFF8);
    advance(); sample(); chk("wrap_cur1", bus.oCurPc, 32'hFFFF_FFFC);
    advance(); sample(); chk("wrap_cur2", bus.oCurPc, 32'h0);

    // Misaligned redirect: sticky error, no further reads until reset
    advance(); bus.iRedirect = 1'b1; bus.iRedirectPc = 32'h102;
    sample(); chk1("mis_no_read", bus.oImemRe, 1'b0);
    advance(); bus.iRedirect = 1'b0; exp_q.delete();
    sample();
    chk1("mis_flag", bus.oMisalign, 1'b1);
    chk1("mis_valid", bus.oValid, 1'b0);
    repeat (4) begin
      advance(); sample();
      chk1("err_re", bus.oImemRe, 1'b0);
      chk1("err_flag", bus.oMisalign, 1'b1);
    end
    advance(); bus.iRedirect = 1'b1; bus.iRedirectPc = 32'h400;
    sample();
    advance(); bus.iRedirect = 1'b0;
    repeat (3) begin
      sample(); chk1("err_stuck_re", bus.oImemRe, 1'b0);
      advance();
    end
    #1; rst_n = 1'b0; #1;
    exp_q.delete();
    chk1("err_rst_flag", bus.oMisalign, 1'b0);
    advance(); rst_n = 1'b1;
    sample(); chk1("post_err_wait", bus.oImemRe, 1'b0);
    advance(); sample();
    chk1("post_err_re", bus.oImemRe, 1'b1);
    chk("post_err_addr", bus.oImemAddr, 32'h0);

    advance();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
